// File: rtl/shift_arb_pkg.sv
// Shared types and helpers for the shift_arbiter block.
// The request struct is sized for the largest supported configuration; users cast to their widths.
package shift_arb_pkg;

  localparam int MAX_WIDTH = 256;
  localparam int MAX_SELW  = 9;
  localparam int MAX_IDW   = 3;

  function automatic int sel_width(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic [MAX_SELW-1:0]  amt;
    logic [MAX_IDW-1:0]   id;
  } req_t;

endpackage

// File: rtl/shift_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping modulo NREQ.
// Produces a one-hot grant plus its index; no grant when en is low.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] scan;
  logic           found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    scan    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (en && !found && req[scan]) begin
        found     = 1'b1;
        gnt[scan] = 1'b1;
        gnt_idx   = scan;
      end
      scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + 1'b1;
    end
  end

endmodule

// File: rtl/shift_arbiter_shifter.sv
// Logarithmic logical right barrel shifter, zero-filled.
// Shift amounts are limited to 0..WIDTH-1; callers handle larger amounts.
module lsr_shifter #(
  parameter  int WIDTH = 8,
  localparam int LW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [LW-1:0]    amt,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage [LW+1];

  assign stage[0] = data;

  for (genvar s = 0; s < LW; s++) begin : g_stage
    assign stage[s+1] = amt[s] ? (stage[s] >> (1 << s)) : stage[s];
  end

  assign result = stage[LW];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding one shared right barrel shifter through a two-stage pipeline.
// Define SHIFT_STICKY_EN to add rsp_sticky (OR of all bits shifted out).
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 2,
  localparam int SELW  = sel_width(WIDTH),
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  input  logic [NREQ*SELW-1:0]   req_amt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
`ifdef SHIFT_STICKY_EN
  output logic                   rsp_sticky,
`endif
  output logic [IDW-1:0]         rsp_id
);

  req_t             s1;
  logic             s1_valid;
  logic [IDW-1:0]   rr_ptr;

  logic             s2_load;
  logic             s1_free;
  logic             accept;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   ptr_next;

  logic [WIDTH-1:0] sel_data;
  logic [SELW-1:0]  sel_amt;
  logic [WIDTH-1:0] s1_data;
  logic [SELW-1:0]  s1_amt;
  logic [IDW-1:0]   s1_id;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result;
  logic             oversize;

  // S1 frees up whenever it moves into S2, so a stalled S2 still lets an empty S1 fill once.
  assign s2_load = s1_valid && (!rsp_valid || rsp_ready);
  assign s1_free = !s1_valid || s2_load;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (s1_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign sel_data = req_data[gnt_idx*WIDTH +: WIDTH];
  assign sel_amt  = req_amt[gnt_idx*SELW +: SELW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s1_valid <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      if (accept) begin
        s1.data  <= MAX_WIDTH'(sel_data);
        s1.amt   <= MAX_SELW'(sel_amt);
        s1.id    <= MAX_IDW'(gnt_idx);
        s1_valid <= 1'b1;
        rr_ptr   <= ptr_next;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign s1_data = WIDTH'(s1.data);
  assign s1_amt  = SELW'(s1.amt);
  assign s1_id   = IDW'(s1.id);

  lsr_shifter #(.WIDTH(WIDTH)) u_shift (
    .data   (s1_data),
    .amt    (s1_amt[SELW-2:0]),
    .result (shifted)
  );

  // WIDTH is a power of two, so the amount MSB alone flags amt >= WIDTH.
  assign oversize = s1_amt[SELW-1];
  assign result   = oversize ? '0 : shifted;

`ifdef SHIFT_STICKY_EN
  logic sticky;
  assign sticky = oversize ? |s1_data
                           : |(s1_data & ~({WIDTH{1'b1}} << s1_amt[SELW-2:0]));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
`ifdef SHIFT_STICKY_EN
      rsp_sticky <= 1'b0;
`endif
    end else if (s2_load) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= result;
      rsp_id     <= s1_id;
`ifdef SHIFT_STICKY_EN
      rsp_sticky <= sticky;
`endif
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter (WIDTH=8, NREQ=3): directed corner cases plus random traffic.
// Sticky checks are active when SHIFT_STICKY_EN is defined.
module tb_shift_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 3;
  localparam int SELW  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*SELW-1:0]  req_amt;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
`ifdef SHIFT_STICKY_EN
  logic                  rsp_sticky;
`endif

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
`ifdef SHIFT_STICKY_EN
    .rsp_sticky (rsp_sticky),
`endif
    .rsp_id     (rsp_id)
  );

  typedef struct {
    int id;
    int data;
    int sticky;
  } exp_t;

  exp_t            sbq[$];
  int              id_log[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              acc_count = 0;
  int              rsp_count = 0;
  int              model_ptr = 0;
  logic [NREQ-1:0] acc_vec = '0;

  logic [NREQ-1:0] pv;
  logic [WIDTH-1:0] pd [NREQ];
  logic [SELW-1:0]  pa [NREQ];

  logic             held = 1'b0;
  logic [WIDTH-1:0] h_data;
  logic [IDW-1:0]   h_id;
  logic             h_sticky;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: plain arithmetic on the shift rules.
  function automatic exp_t model(input int id, input int d, input int a);
    exp_t e;
    e.id = id;
    if (a >= WIDTH) begin
      e.data   = 0;
      e.sticky = (d != 0) ? 1 : 0;
    end else begin
      e.data   = d / (1 << a);
      e.sticky = ((d % (1 << a)) != 0) ? 1 : 0;
    end
    return e;
  endfunction

  // Request side: round-robin expectation and scoreboard push on each transfer.
  always @(negedge clk) begin
    int eg;
    acc_vec = '0;
    if (rst) begin
      model_ptr = 0;
    end else if (req_ready != '0) begin
      eg = -1;
      for (int k = 0; k < NREQ; k++)
        if (eg < 0 && req_valid[(model_ptr + k) % NREQ]) eg = (model_ptr + k) % NREQ;
      check("ready_onehot", $countones(req_ready), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          check("grant_rr", i, eg);
          if (req_valid[i]) begin
            sbq.push_back(model(i, int'(req_data[i*WIDTH +: WIDTH]), int'(req_amt[i*SELW +: SELW])));
            acc_vec[i] = 1'b1;
            acc_count++;
            model_ptr = (i + 1) % NREQ;
          end
        end
      end
    end
  end

  // Response side: stall stability and in-order scoreboard comparison.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", rsp_valid, 1);
        check("stall_data", rsp_data, h_data);
        check("stall_id", rsp_id, h_id);
`ifdef SHIFT_STICKY_EN
        check("stall_sticky", rsp_sticky, h_sticky);
`endif
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_id", rsp_id, e.id);
`ifdef SHIFT_STICKY_EN
          check("rsp_sticky", rsp_sticky, e.sticky);
`endif
          id_log.push_back(int'(rsp_id));
          rsp_count++;
        end
      end
      held   = rsp_valid && !rsp_ready;
      h_data = rsp_data;
      h_id   = rsp_id;
`ifdef SHIFT_STICKY_EN
      h_sticky = rsp_sticky;
`else
      h_sticky = 1'b0;
`endif
    end
  end

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                = pv[i];
      req_data[i*WIDTH +: WIDTH]  = pd[i];
      req_amt[i*SELW +: SELW]     = pa[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pv = pv & ~acc_vec;
    apply();
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!pv[i] && $urandom_range(0, 99) < pct) begin
        pv[i] = 1'b1;
        pd[i] = WIDTH'($urandom);
        pa[i] = SELW'($urandom_range(0, 15));
      end
    end
    apply();
  endtask

  task automatic drain();
    pv = '0;
    rsp_ready = 1'b1;
    apply();
    repeat (6) step();
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic single(input int id, input logic [WIDTH-1:0] d, input logic [SELW-1:0] a,
                        input logic [WIDTH-1:0] exp_d, input logic exp_s);
    int t;
    int lat;
    pv = '0;
    pv[id] = 1'b1;
    pd[id] = d;
    pa[id] = a;
    rsp_ready = 1'b1;
    apply();
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!acc_vec[id] && t < 20);
    check("single_accept", acc_vec[id], 1);
    @(posedge clk);
    #1;
    pv[id] = 1'b0;
    apply();
    lat = 1;
    @(negedge clk);
    #1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("single_latency", lat, 2);
    check("single_data", rsp_data, exp_d);
    check("single_id", rsp_id, id);
`ifdef SHIFT_STICKY_EN
    check("single_sticky", rsp_sticky, exp_s);
`else
    if (exp_s === 1'bx) check("single_sticky_arg", exp_s, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int r0;
    int l0;

    rst       = 1'b1;
    rsp_ready = 1'b0;
    pv        = '0;
    for (int i = 0; i < NREQ; i++) begin
      pd[i] = '0;
      pa[i] = '0;
    end
    apply();
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
`ifdef SHIFT_STICKY_EN
    check("reset_rsp_sticky", rsp_sticky, 0);
`endif
    check("reset_ready_idle", req_ready, 0);
    pv = '0;
    refill(100);
    #1;
    check("reset_ready_arb", req_ready, 3'b001);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Fairness: all requesters valid continuously.
    a0 = acc_count;
    r0 = rsp_count;
    l0 = id_log.size();
    repeat (12) begin
      step();
      refill(100);
    end
    check("fair_accepts", acc_count - a0, 12);
    check("fair_rsp_rate", rsp_count - r0, 10);
    for (int j = 0; j < 6; j++)
      check("fair_order", (id_log.size() > l0 + j) ? id_log[l0 + j] : -1, j % 3);
    drain();

    single(0, 8'hB5, 4'd3,  8'h16, 1'b1);
    single(1, 8'h80, 4'd8,  8'h00, 1'b1);
    single(2, 8'h00, 4'd15, 8'h00, 1'b0);
    single(0, 8'h7F, 4'd0,  8'h7F, 1'b0);
    drain();

    // Backpressure from an idle pipeline.
    rsp_ready = 1'b0;
    a0 = acc_count;
    r0 = rsp_count;
    pv = '0;
    refill(100);
    repeat (7) begin
      step();
      refill(100);
    end
    check("bp_accepts", acc_count - a0, 2);
    check("bp_ready_low", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_no_rsp", rsp_count - r0, 0);
    rsp_ready = 1'b1;
    repeat (10) begin
      step();
      refill(100);
    end
    drain();

    // Reset with S1 and S2 both full.
    rsp_ready = 1'b0;
    pv = '0;
    refill(100);
    repeat (2) step();
    rst = 1'b1;
    pv = '0;
    apply();
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data", rsp_data, 0);
    sbq.delete();
    repeat (2) step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    r0 = rsp_count;
    repeat (6) begin
      step();
      check("midrst_no_stale", rsp_valid, 0);
    end
    check("midrst_rsp_count", rsp_count - r0, 0);

    // Random traffic with random backpressure.
    a0 = acc_count;
    r0 = rsp_count;
    repeat (400) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      refill(60);
    end
    drain();
    check("rand_conserved", (acc_count - a0) - (rsp_count - r0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
